// File: rtl/regbank_sb_if.sv
// Bundles the decode and writeback signals of the regbank_sb register bank.
// The master drives requests and the slave (the bank) returns read data, stall and busy.
interface regbank_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) ();
  localparam int NREGS = 1 << ADDR_W;

  logic              rd_en;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              data_valid;
  logic              stall;
  logic              wr_en;
  logic [ADDR_W-1:0] addrdest;
  logic [DATA_W-1:0] datadest;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [NREGS-1:0]  busy;

  modport master (
    output rd_en, addr1, addr2, wr_en, addrdest, datadest, rsv_en, rsv_addr,
    input  data1, data2, data_valid, stall, busy
  );

  modport slave (
    input  rd_en, addr1, addr2, wr_en, addrdest, datadest, rsv_en, rsv_addr,
    output data1, data2, data_valid, stall, busy
  );
endinterface

// File: rtl/regbank_sb.sv
// Two-read/one-write register bank with registered reads and a busy scoreboard.
// Define REGBANK_BYPASS_EN to forward same-cycle write data to a matching read port.
module regbank_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic        clk,
  input  logic        reset,
  regbank_sb_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NREGS-1:0]  wr_sel, rsv_sel;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic              valid_q, valid_d;

  logic              zero1, zero2;
  logic              byp1, byp2;
  logic              hz1, hz2;
  logic              accept;
  logic [DATA_W-1:0] rd1, rd2;

  // Per-register write/reserve decode; a constant-zero register 0 never gets selected.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sel
      localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);
      assign wr_sel[gi]  = bus.wr_en  && (bus.addrdest == ADDR_W'(gi)) && !IS_ZERO;
      assign rsv_sel[gi] = bus.rsv_en && (bus.rsv_addr == ADDR_W'(gi)) && !IS_ZERO;
    end
  endgenerate

  always_comb begin
    zero1 = (ZERO_REG != 0) && (bus.addr1 == '0);
    zero2 = (ZERO_REG != 0) && (bus.addr2 == '0);
`ifdef REGBANK_BYPASS_EN
    byp1  = bus.wr_en && (bus.addrdest == bus.addr1) && !zero1;
    byp2  = bus.wr_en && (bus.addrdest == bus.addr2) && !zero2;
`else
    byp1  = 1'b0;
    byp2  = 1'b0;
`endif
    hz1   = busy_q[bus.addr1] && !byp1;
    hz2   = busy_q[bus.addr2] && !byp2;
    rd1   = zero1 ? '0 : (byp1 ? bus.datadest : regs_q[bus.addr1]);
    rd2   = zero2 ? '0 : (byp2 ? bus.datadest : regs_q[bus.addr2]);
    accept = bus.rd_en && !(hz1 || hz2);
  end

  // Reservation is applied after the write clear so a same-address collision stays busy.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = wr_sel[i] ? bus.datadest : regs_q[i];
    end
    busy_d  = (busy_q & ~wr_sel) | rsv_sel;
    data1_d = accept ? rd1 : data1_q;
    data2_d = accept ? rd2 : data2_q;
    valid_d = accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
      valid_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      valid_q <= valid_d;
    end
  end

  assign bus.stall      = bus.rd_en && (hz1 || hz2);
  assign bus.data1      = data1_q;
  assign bus.data2      = data2_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_regbank_sb.sv
// Scoreboard bench for regbank_sb: two instances (ZERO_REG 0 and 1) share one stimulus
// stream and are checked against an array-based reference model of the register bank.
module tb_regbank_sb;
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  regbank_sb_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
  regbank_sb_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

  regbank_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  regbank_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents and busy flags per instance.
  int          m_regs [2][8];
  bit          m_busy [2][8];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  logic [15:0] last_exp [2];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < 8; r++) begin
        m_regs[z][r] = 0;
        m_busy[z][r] = 1'b0;
      end
      last_exp[z] = 16'h0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Called at posedge+1; checks the combinational/registered status, then advances the model.
  task automatic cycle(input bit rd, input int a1, input int a2, input bit wr, input int ad,
                       input int dd, input bit rs, input int ra);
    bus0.rd_en = rd; bus0.addr1 = 3'(a1); bus0.addr2 = 3'(a2);
    bus0.wr_en = wr; bus0.addrdest = 3'(ad); bus0.datadest = 8'(dd);
    bus0.rsv_en = rs; bus0.rsv_addr = 3'(ra);
    bus1.rd_en = rd; bus1.addr1 = 3'(a1); bus1.addr2 = 3'(a2);
    bus1.wr_en = wr; bus1.addrdest = 3'(ad); bus1.datadest = 8'(dd);
    bus1.rsv_en = rs; bus1.rsv_addr = 3'(ra);
    #3;
    for (int z = 0; z < 2; z++) begin
      bit   zr1, zr2, byp1, byp2, st;
      int   v1, v2;
      logic [7:0] exp_busy;
      zr1  = (z == 1) && (a1 == 0);
      zr2  = (z == 1) && (a2 == 0);
      byp1 = BYP && wr && (ad == a1) && !zr1;
      byp2 = BYP && wr && (ad == a2) && !zr2;
      st   = rd && ((m_busy[z][a1] && !byp1) || (m_busy[z][a2] && !byp2));
      for (int r = 0; r < 8; r++) exp_busy[r] = m_busy[z][r];
      check($sformatf("stall dut%0d", z), int'(z == 0 ? bus0.stall : bus1.stall), int'(st));
      check($sformatf("busy dut%0d", z), int'(z == 0 ? bus0.busy : bus1.busy), int'(exp_busy));
      if (rd && !st) begin
        v1 = zr1 ? 0 : (byp1 ? dd : m_regs[z][a1]);
        v2 = zr2 ? 0 : (byp2 ? dd : m_regs[z][a2]);
        if (z == 0) exp_q0.push_back({8'(v1), 8'(v2)});
        else        exp_q1.push_back({8'(v1), 8'(v2)});
      end
      if (wr && !((z == 1) && (ad == 0))) begin
        m_regs[z][ad] = dd;
        m_busy[z][ad] = 1'b0;
      end
      if (rs && !((z == 1) && (ra == 0))) m_busy[z][ra] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mon_one(input int z, input logic v, input logic [7:0] d1, input logic [7:0] d2);
    logic [15:0] e;
    if (v) begin
      check($sformatf("valid-expected dut%0d", z), int'(z == 0 ? exp_q0.size() > 0 : exp_q1.size() > 0), 1);
      if ((z == 0 && exp_q0.size() > 0) || (z == 1 && exp_q1.size() > 0)) begin
        e = (z == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        last_exp[z] = e;
        check($sformatf("data1 dut%0d", z), int'(d1), int'(e[15:8]));
        check($sformatf("data2 dut%0d", z), int'(d2), int'(e[7:0]));
        $display("read dut%0d data1=0x%02h data2=0x%02h", z, d1, d2);
      end
    end else begin
      check($sformatf("data1 hold dut%0d", z), int'(d1), int'(last_exp[z][15:8]));
      check($sformatf("data2 hold dut%0d", z), int'(d2), int'(last_exp[z][7:0]));
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, bus0.data_valid, bus0.data1, bus0.data2);
    mon_one(1, bus1.data_valid, bus1.data1, bus1.data2);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    model_reset();
    bus0.rd_en = 0; bus0.addr1 = 0; bus0.addr2 = 0; bus0.wr_en = 0;
    bus0.addrdest = 0; bus0.datadest = 0; bus0.rsv_en = 0; bus0.rsv_addr = 0;
    bus1.rd_en = 0; bus1.addr1 = 0; bus1.addr2 = 0; bus1.wr_en = 0;
    bus1.addrdest = 0; bus1.datadest = 0; bus1.rsv_en = 0; bus1.rsv_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset data_valid", int'(bus0.data_valid), 0);
    check("reset busy", int'(bus0.busy), 0);

    // Reset mid-read: r3 = 0x5A is being returned when reset hits.
    cycle(0, 0, 0, 1, 3, 'h5A, 0, 0);
    cycle(1, 3, 3, 0, 0, 0, 0, 0);
    check("pre-reset data_valid", int'(bus0.data_valid), 1);
    #1;
    reset = 1'b1;
    bus0.rd_en = 0; bus1.rd_en = 0;
    #1;
    check("async reset data1", int'(bus0.data1), 0);
    check("async reset data2", int'(bus0.data2), 0);
    check("async reset data_valid", int'(bus0.data_valid), 0);
    check("async reset busy", int'(bus0.busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1, 3, 3, 0, 0, 0, 0, 0);

    // Basic write then read.
    cycle(0, 0, 0, 1, 5, 'hA7, 0, 0);
    cycle(1, 5, 5, 0, 0, 0, 0, 0);

    // Scoreboard stall and release by write.
    cycle(0, 0, 0, 0, 0, 0, 1, 2);
    cycle(1, 2, 2, 0, 0, 0, 0, 0);
    cycle(1, 2, 2, 1, 2, 'h33, 0, 0);
    cycle(1, 2, 2, 0, 0, 0, 0, 0);

    // Reserve and write collide on r4.
    cycle(0, 0, 0, 1, 4, 'h11, 1, 4);
    cycle(1, 4, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 4, 'h44, 0, 0);
    cycle(1, 4, 4, 0, 0, 0, 0, 0);

    // Same-cycle write and read of non-busy r6.
    cycle(0, 0, 0, 1, 6, 'h01, 0, 0);
    cycle(1, 1, 6, 1, 6, 'hFE, 0, 0);
    cycle(1, 6, 6, 0, 0, 0, 0, 0);

    // Register 0 write/reserve: constant zero on the ZERO_REG instance.
    cycle(0, 0, 0, 1, 0, 'hFF, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 7, 1, 0, 'h00, 0, 0);
    cycle(1, 0, 7, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(9) < 7), $urandom_range(7), $urandom_range(7),
            ($urandom_range(1) == 1), $urandom_range(7), $urandom_range(255),
            ($urandom_range(9) < 3), $urandom_range(7));
    end

    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("pending reads dut0", exp_q0.size(), 0);
    check("pending reads dut1", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
